// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one single-ported, fixed-latency memory
// between instruction fetch (requester 0) and data access (requester 1).
// Each access takes one IDLE arbitration cycle, MEM_LATENCY ACCESS cycles
// and one DONE cycle; operands are latched at the grant so requesters may
// change their inputs freely while the access is in flight.
module mem_port_arbiter #(
  parameter int MEM_LATENCY = 2,
  parameter int DATA_W      = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req0,
  input  logic [DATA_W-1:0] addr0,
  input  logic [DATA_W-1:0] wdata0,
  input  logic              we0,
  input  logic              req1,
  input  logic [DATA_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata1,
  input  logic              we1,
  output logic              gnt0,
  output logic              gnt1,
  output logic              done0,
  output logic              done1,
  output logic [DATA_W-1:0] rdata,
  output logic              sel,
  output logic              mem_en,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  // Counter starts at MEM_LATENCY-1 so ACCESS lasts exactly MEM_LATENCY cycles.
  localparam logic [7:0] CNT_LOAD = 8'(MEM_LATENCY - 1);

  state_t            state;
  state_t            next_state;
  logic [7:0]        cnt_p0;
  logic              sel_p0;
  logic              last_winner;
  logic              we_p0;
  logic [DATA_W-1:0] addr_p0;
  logic [DATA_W-1:0] wdata_p0;
  logic [DATA_W-1:0] rdata_p1;
  logic              any_req;
  logic              winner;
  logic              win;
  logic              first_access;

  // Round-robin pick: a lone requester wins outright, a tie goes to the
  // requester that did not win the previous access.
  function automatic logic pick_winner(input logic r0, input logic r1,
                                       input logic last);
    logic w;
    if (r0 && r1) begin
      w = ~last;
    end else begin
      w = r1;
    end
    return w;
  endfunction

  assign any_req = req0 | req1;
  assign winner  = pick_winner(req0, req1, last_winner);
  assign win     = (state == IDLE) && any_req;

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state decode: IDLE waits for a request, ACCESS runs until the
  // latency counter expires, DONE is always a single cycle.
  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (any_req) begin
          next_state = ACCESS;
        end
      end
      ACCESS: begin
        if (cnt_p0 == 8'd0) begin
          next_state = DONE;
        end
      end
      DONE: begin
        next_state = IDLE;
      end
      default: begin
        next_state = IDLE;
      end
    endcase
  end

  // Latency counter: reloaded every IDLE cycle, counts down through ACCESS.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_p0 <= 8'd0;
    end else if (state == IDLE) begin
      cnt_p0 <= CNT_LOAD;
    end else if ((state == ACCESS) && (cnt_p0 != 8'd0)) begin
      cnt_p0 <= cnt_p0 - 8'd1;
    end
  end

  // Grant stage: latch the winner's operands and the mux select so the
  // memory sees stable values for the whole access.
  always_ff @(posedge clk) begin
    if (reset) begin
      sel_p0   <= 1'b0;
      we_p0    <= 1'b0;
      addr_p0  <= '0;
      wdata_p0 <= '0;
    end else if (win) begin
      sel_p0   <= winner;
      we_p0    <= winner ? we1 : we0;
      addr_p0  <= winner ? addr1 : addr0;
      wdata_p0 <= winner ? wdata1 : wdata0;
    end
  end

  // Fairness history: updated only when an access actually completes, so an
  // aborted access does not count as a win.
  always_ff @(posedge clk) begin
    if (reset) begin
      last_winner <= 1'b1;
    end else if (state == DONE) begin
      last_winner <= sel_p0;
    end
  end

  // Read-return stage: capture memory data on the last ACCESS edge of a read;
  // writes leave the previous read data in place.
  always_ff @(posedge clk) begin
    if (reset) begin
      rdata_p1 <= '0;
    end else if ((state == ACCESS) && (cnt_p0 == 8'd0) && !we_p0) begin
      rdata_p1 <= mem_rdata;
    end
  end

  // The counter still holds its load value only in the first ACCESS cycle.
  assign first_access = (state == ACCESS) && (cnt_p0 == CNT_LOAD);

  assign mem_en    = (state == ACCESS);
  assign mem_we    = mem_en & we_p0;
  assign mem_addr  = addr_p0;
  assign mem_wdata = wdata_p0;
  assign sel       = sel_p0;
  assign rdata     = rdata_p1;

  assign gnt0  = first_access & ~sel_p0;
  assign gnt1  = first_access &  sel_p0;
  assign done0 = (state == DONE) & ~sel_p0;
  assign done1 = (state == DONE) &  sel_p0;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: two instances (MEM_LATENCY=2 and 1) share one
// stimulus stream; a timeline reference model per instance predicts outputs.
module tb_mem_port_arbiter;

  logic        clk;
  logic        reset;
  logic        req0, req1, we0, we1;
  logic [31:0] addr0, addr1, wdata0, wdata1, mem_rdata;

  logic [1:0]  o_gnt0, o_gnt1, o_done0, o_done1, o_sel, o_en, o_we;
  logic [31:0] o_addr  [2];
  logic [31:0] o_wdata [2];
  logic [31:0] o_rdata [2];

  int errors = 0;
  int checks = 0;

  // Reference model state, one slot per instance; an access is described by
  // its first ACCESS cycle number, from which every output is derived.
  int          lat [2] = '{2, 1};
  int          m_cyc   [2];
  int          m_start [2];
  logic        m_busy  [2];
  logic        m_who   [2];
  logic        m_last  [2];
  logic        m_sel   [2];
  logic        m_we    [2];
  logic [31:0] m_addr  [2];
  logic [31:0] m_wdata [2];
  logic [31:0] m_rdata [2];

  mem_port_arbiter #(.MEM_LATENCY(2)) dut_l2 (
    .clk(clk), .reset(reset),
    .req0(req0), .addr0(addr0), .wdata0(wdata0), .we0(we0),
    .req1(req1), .addr1(addr1), .wdata1(wdata1), .we1(we1),
    .gnt0(o_gnt0[0]), .gnt1(o_gnt1[0]), .done0(o_done0[0]), .done1(o_done1[0]),
    .rdata(o_rdata[0]), .sel(o_sel[0]), .mem_en(o_en[0]), .mem_we(o_we[0]),
    .mem_addr(o_addr[0]), .mem_wdata(o_wdata[0]), .mem_rdata(mem_rdata)
  );

  mem_port_arbiter #(.MEM_LATENCY(1)) dut_l1 (
    .clk(clk), .reset(reset),
    .req0(req0), .addr0(addr0), .wdata0(wdata0), .we0(we0),
    .req1(req1), .addr1(addr1), .wdata1(wdata1), .we1(we1),
    .gnt0(o_gnt0[1]), .gnt1(o_gnt1[1]), .done0(o_done0[1]), .done1(o_done1[1]),
    .rdata(o_rdata[1]), .sel(o_sel[1]), .mem_en(o_en[1]), .mem_we(o_we[1]),
    .mem_addr(o_addr[1]), .mem_wdata(o_wdata[1]), .mem_rdata(mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic x_en(int k);
    return m_busy[k] && (m_cyc[k] >= m_start[k]) && (m_cyc[k] < m_start[k] + lat[k]);
  endfunction

  function automatic logic x_gnt(int k, logic who);
    return m_busy[k] && (m_cyc[k] == m_start[k]) && (m_who[k] == who);
  endfunction

  function automatic logic x_done(int k, logic who);
    return m_busy[k] && (m_cyc[k] == m_start[k] + lat[k]) && (m_who[k] == who);
  endfunction

  // Consume the inputs presented during the current cycle and move the model
  // to the next cycle.
  task automatic model_advance(int k);
    logic w;
    if (reset) begin
      m_busy[k]  = 1'b0;
      m_sel[k]   = 1'b0;
      m_last[k]  = 1'b1;
      m_rdata[k] = '0;
    end else if (m_busy[k]) begin
      if ((m_cyc[k] == m_start[k] + lat[k] - 1) && !m_we[k]) m_rdata[k] = mem_rdata;
      if (m_cyc[k] == m_start[k] + lat[k]) begin
        m_last[k] = m_who[k];
        m_busy[k] = 1'b0;
      end
    end else if (req0 || req1) begin
      w = (req0 && req1) ? ~m_last[k] : req1;
      m_busy[k]  = 1'b1;
      m_who[k]   = w;
      m_sel[k]   = w;
      m_start[k] = m_cyc[k] + 1;
      m_we[k]    = w ? we1 : we0;
      m_addr[k]  = w ? addr1 : addr0;
      m_wdata[k] = w ? wdata1 : wdata0;
    end
    m_cyc[k]++;
  endtask

  task automatic tick();
    for (int k = 0; k < 2; k++) model_advance(k);
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    req0 = 0; req1 = 0; we0 = 0; we1 = 0;
    addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0; mem_rdata = '0;
  endtask

  // Leaves the bench in cycle 0: first IDLE cycle after reset.
  task automatic do_reset();
    clear_inputs();
    reset = 1;
    tick();
    tick();
    reset = 0;
  endtask

  task automatic test_reset();
    logic [102:0] act;
    do_reset();
    req0 = 1; req1 = 1; addr0 = '1; addr1 = '1; wdata0 = '1; wdata1 = '1;
    mem_rdata = '1;
    repeat (6) tick();
    reset = 1;
    tick();
    reset = 0;
    clear_inputs();
    for (int k = 0; k < 2; k++) begin
      act = {o_gnt0[k], o_gnt1[k], o_done0[k], o_done1[k], o_sel[k], o_en[k], o_we[k],
             o_addr[k], o_wdata[k], o_rdata[k]};
      checks++;
      if (act !== 103'd0) begin
        errors++;
        $display("FAIL reset_state inst=%0d: got %h required 0", k, act);
      end
    end
  endtask

  task automatic test_single_read();
    do_reset();
    req0 = 1; addr0 = 32'h40; we0 = 0; mem_rdata = 32'hDEAD_BEEF;
    tick();  // cycle 1
    checks++;
    if ({o_gnt0[0], o_gnt1[0], o_en[0], o_sel[0]} !== 4'b1010) begin
      errors++;
      $display("FAIL read_c1_ctrl: got %b required 1010",
               {o_gnt0[0], o_gnt1[0], o_en[0], o_sel[0]});
    end
    checks++;
    if (o_addr[0] !== 32'h40) begin
      errors++;
      $display("FAIL read_c1_addr: got %h required 00000040", o_addr[0]);
    end
    tick();  // cycle 2
    checks++;
    if ({o_gnt0[0], o_en[0], o_done0[0]} !== 3'b010) begin
      errors++;
      $display("FAIL read_c2_ctrl: got %b required 010", {o_gnt0[0], o_en[0], o_done0[0]});
    end
    tick();  // cycle 3
    req0 = 0;
    checks++;
    if ({o_done0[0], o_done1[0], o_en[0], o_sel[0]} !== 4'b1000) begin
      errors++;
      $display("FAIL read_c3_done: got %b required 1000",
               {o_done0[0], o_done1[0], o_en[0], o_sel[0]});
    end
    checks++;
    if (o_rdata[0] !== 32'hDEAD_BEEF) begin
      errors++;
      $display("FAIL read_rdata: got %h required deadbeef", o_rdata[0]);
    end
    tick();
  endtask

  task automatic test_tie_after_reset();
    do_reset();
    req0 = 1; req1 = 1; addr0 = 32'h10; addr1 = 32'h20;
    for (int c = 1; c <= 7; c++) begin
      tick();
      if (c == 1) begin
        checks++;
        if ({o_gnt0[0], o_gnt1[0], o_sel[0]} !== 3'b100) begin
          errors++;
          $display("FAIL tie_first_gnt: got %b required 100", {o_gnt0[0], o_gnt1[0], o_sel[0]});
        end
      end
      if (c == 3) begin
        checks++;
        if ({o_done0[0], o_done1[0]} !== 2'b10) begin
          errors++;
          $display("FAIL tie_done0: got %b required 10", {o_done0[0], o_done1[0]});
        end
      end
      if (c == 5) begin
        checks++;
        if ({o_gnt0[0], o_gnt1[0], o_sel[0], o_addr[0]} !== {3'b011, 32'h20}) begin
          errors++;
          $display("FAIL tie_second_gnt: got %b/%h required 011/00000020",
                   {o_gnt0[0], o_gnt1[0], o_sel[0]}, o_addr[0]);
        end
      end
      if (c == 7) begin
        checks++;
        if ({o_done0[0], o_done1[0]} !== 2'b01) begin
          errors++;
          $display("FAIL tie_done1: got %b required 01", {o_done0[0], o_done1[0]});
        end
      end
    end
    clear_inputs();
    tick();
  endtask

  task automatic test_alternation();
    int g_cyc [8];
    int g_who [8];
    int d_cyc [8];
    int ng, nd;
    ng = 0; nd = 0;
    do_reset();
    req0 = 1; req1 = 1; addr0 = 32'hA0; addr1 = 32'hB0;
    for (int c = 1; c <= 24; c++) begin
      tick();
      checks++;
      if ((o_gnt0[0] & o_gnt1[0]) || (o_done0[0] & o_done1[0]) ||
          ((o_gnt0[0] | o_gnt1[0]) & (o_done0[0] | o_done1[0]))) begin
        errors++;
        $display("FAIL alt_exclusive cycle=%0d: gnt=%b done=%b required one-hot, disjoint",
                 c, {o_gnt0[0], o_gnt1[0]}, {o_done0[0], o_done1[0]});
      end
      if ((o_gnt0[0] | o_gnt1[0]) && ng < 8) begin
        g_cyc[ng] = c; g_who[ng] = o_gnt1[0] ? 1 : 0; ng++;
      end
      if ((o_done0[0] | o_done1[0]) && nd < 8) begin
        d_cyc[nd] = c; nd++;
      end
    end
    checks++;
    if (ng != 6 || nd != 6) begin
      errors++;
      $display("FAIL alt_count: got grants=%0d dones=%0d required 6/6", ng, nd);
    end
    for (int i = 0; i < ng && i < nd; i++) begin
      checks++;
      if (g_who[i] != (i % 2) || g_cyc[i] != 1 + 4 * i || d_cyc[i] != 3 + 4 * i) begin
        errors++;
        $display("FAIL alt_order idx=%0d: got who=%0d gnt@%0d done@%0d required who=%0d gnt@%0d done@%0d",
                 i, g_who[i], g_cyc[i], d_cyc[i], i % 2, 1 + 4 * i, 3 + 4 * i);
      end
    end
    clear_inputs();
    tick();
  endtask

  task automatic test_write_keeps_rdata();
    do_reset();
    req0 = 1; addr0 = 32'h80; mem_rdata = 32'hA5A5_A5A5;
    repeat (3) tick();  // cycle 3: done0
    checks++;
    if (o_done0[0] !== 1'b1 || o_rdata[0] !== 32'hA5A5_A5A5) begin
      errors++;
      $display("FAIL wr_prior_read: got done0=%b rdata=%h required 1/a5a5a5a5", o_done0[0], o_rdata[0]);
    end
    req0 = 0; req1 = 1; we1 = 1; addr1 = 32'h100; wdata1 = 32'h1234_5678;
    mem_rdata = 32'h0BAD_0BAD;
    tick();  // cycle 4 idle
    for (int c = 5; c <= 6; c++) begin
      tick();
      checks++;
      if ({o_en[0], o_we[0], o_sel[0], o_addr[0], o_wdata[0]} !== {3'b111, 32'h100, 32'h1234_5678}) begin
        errors++;
        $display("FAIL wr_access cycle=%0d: got en/we/sel=%b addr=%h wdata=%h required 111/00000100/12345678",
                 c, {o_en[0], o_we[0], o_sel[0]}, o_addr[0], o_wdata[0]);
      end
    end
    tick();  // cycle 7
    checks++;
    if (o_done1[0] !== 1'b1 || o_rdata[0] !== 32'hA5A5_A5A5) begin
      errors++;
      $display("FAIL wr_done: got done1=%b rdata=%h required 1/a5a5a5a5", o_done1[0], o_rdata[0]);
    end
    clear_inputs();
    tick();
  endtask

  task automatic test_reset_mid_access();
    do_reset();
    req0 = 1; addr0 = 32'h44; mem_rdata = 32'h7777_0000;
    repeat (3) tick();  // cycle 3: done0, rdata now nonzero
    req0 = 0; req1 = 1; we1 = 0; addr1 = 32'h200; mem_rdata = 32'h1111_2222;
    tick();             // cycle 4 idle
    tick();             // cycle 5 first access
    checks++;
    if (o_gnt1[0] !== 1'b1) begin
      errors++;
      $display("FAIL rst_mid_gnt1: got %b required 1", o_gnt1[0]);
    end
    tick();             // cycle 6 second access
    reset = 1;
    tick();             // cycle 7
    reset = 0;
    checks++;
    if ({o_en[0], o_done1[0], o_sel[0], o_rdata[0]} !== {3'b000, 32'h0}) begin
      errors++;
      $display("FAIL rst_mid_abort: got en/done1/sel=%b rdata=%h required 000/00000000",
               {o_en[0], o_done1[0], o_sel[0]}, o_rdata[0]);
    end
    req0 = 1; req1 = 1;
    tick();             // cycle 8
    checks++;
    if ({o_gnt0[0], o_gnt1[0], o_sel[0], o_done1[0]} !== 4'b1000) begin
      errors++;
      $display("FAIL rst_mid_tie: got %b required 1000",
               {o_gnt0[0], o_gnt1[0], o_sel[0], o_done1[0]});
    end
    clear_inputs();
    repeat (3) tick();
  endtask

  task automatic test_latency1();
    do_reset();
    req0 = 1; addr0 = 32'h300; mem_rdata = 32'hCAFE_F00D;
    tick();  // cycle 1
    addr0 = 32'h999;
    #1;
    checks++;
    if ({o_gnt0[1], o_en[1], o_sel[1], o_addr[1]} !== {3'b110, 32'h300}) begin
      errors++;
      $display("FAIL l1_gnt: got %b/%h required 110/00000300", {o_gnt0[1], o_en[1], o_sel[1]}, o_addr[1]);
    end
    tick();  // cycle 2
    checks++;
    if ({o_done0[1], o_en[1], o_rdata[1]} !== {2'b10, 32'hCAFE_F00D}) begin
      errors++;
      $display("FAIL l1_done: got %b/%h required 10/cafef00d", {o_done0[1], o_en[1]}, o_rdata[1]);
    end
    tick();  // cycle 3 idle
    checks++;
    if ({o_gnt0[1], o_en[1], o_done0[1]} !== 3'b000) begin
      errors++;
      $display("FAIL l1_idle: got %b required 000", {o_gnt0[1], o_en[1], o_done0[1]});
    end
    tick();  // cycle 4 regrant with new operand
    checks++;
    if ({o_gnt0[1], o_addr[1]} !== {1'b1, 32'h999}) begin
      errors++;
      $display("FAIL l1_regrant: got %b/%h required 1/00000999", o_gnt0[1], o_addr[1]);
    end
    clear_inputs();
    repeat (2) tick();
  endtask

  task automatic test_random();
    logic [6:0]  act_c, exp_c;
    logic [64:0] act_d, exp_d;
    do_reset();
    for (int c = 0; c < 400; c++) begin
      for (int k = 0; k < 2; k++) begin
        act_c = {o_gnt0[k], o_gnt1[k], o_done0[k], o_done1[k], o_sel[k], o_en[k], o_we[k]};
        exp_c = {x_gnt(k, 1'b0), x_gnt(k, 1'b1), x_done(k, 1'b0), x_done(k, 1'b1),
                 m_sel[k], x_en(k), x_en(k) & m_we[k]};
        checks++;
        if (act_c !== exp_c) begin
          errors++;
          $display("FAIL rand_ctrl inst=%0d cycle=%0d: got %b required %b", k, c, act_c, exp_c);
        end
        checks++;
        if (o_rdata[k] !== m_rdata[k]) begin
          errors++;
          $display("FAIL rand_rdata inst=%0d cycle=%0d: got %h required %h", k, c, o_rdata[k], m_rdata[k]);
        end
        if (x_en(k)) begin
          act_d = {o_we[k], o_addr[k], o_wdata[k]};
          exp_d = {m_we[k], m_addr[k], m_wdata[k]};
          checks++;
          if (act_d !== exp_d) begin
            errors++;
            $display("FAIL rand_mem inst=%0d cycle=%0d: got %h required %h", k, c, act_d, exp_d);
          end
        end
      end
      reset     = ($urandom_range(0, 63) == 0);
      req0      = ($urandom_range(0, 3) != 0);
      req1      = ($urandom_range(0, 2) != 0);
      we0       = $urandom_range(0, 1);
      we1       = $urandom_range(0, 1);
      addr0     = $urandom;
      addr1     = $urandom;
      wdata0    = $urandom;
      wdata1    = $urandom;
      mem_rdata = $urandom;
      tick();
    end
    reset = 0;
    clear_inputs();
  endtask

  initial begin
    reset = 1;
    clear_inputs();
    @(posedge clk);
    #1;
    test_reset();
    test_single_read();
    test_tie_after_reset();
    test_alternation();
    test_write_keeps_rdata();
    test_reset_mid_access();
    test_latency1();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Two-requester, round-robin arbiter that shares one single-ported 32-bit memory between instruction fetch (requester 0) and data access (requester 1).
- It sequences each access over a fixed-latency memory.
- It drives the select line of the shared 2-way 32-bit address/data muxes and returns read data with a one-cycle done pulse to the winning requester.

Parameters:
- MEM_LATENCY, 2, cycles mem_en is held before mem_rdata is valid (legal 1..255).

Ports:
- clk  in  1  system clock, all state updates on rising edge
- reset  in  1  synchronous, active-high reset
- req0  in  1  requester 0 access request (fetch)
- addr0  in  32  requester 0 address
- wdata0  in  32  requester 0 write data
- we0  in  1  requester 0 write enable (1 = write)
- req1  in  1  requester 1 access request (data)
- addr1  in  32  requester 1 address
- wdata1  in  32  requester 1 write data
- we1  in  1  requester 1 write enable
- gnt0  out  1  one-cycle pulse: requester 0 access started
- gnt1  out  1  one-cycle pulse: requester 1 access started
- done0  out  1  one-cycle pulse: requester 0 access complete
- done1  out  1  one-cycle pulse: requester 1 access complete
- rdata  out  32  last read data, valid from done pulse onward
- sel  out  1  shared-mux select (0 = requester 0, 1 = requester 1)
- mem_en  out  1  memory access enable
- mem_we  out  1  memory write enable
- mem_addr  out  32  memory address
- mem_wdata  out  32  memory write data
- mem_rdata  in  32  memory read data

Behaviour:
- Reset (synchronous):
  - state = IDLE; all outputs 0; rdata = 0; sel = 0.
  - last_winner = 1, so requester 0 wins the first tie.
  - Reset mid-ACCESS or mid-DONE aborts the transaction: no done pulse, mem_en drops on the next cycle.
- FSM states: IDLE, ACCESS, DONE.
- IDLE:
  - No request: stay in IDLE, mem_en = 0.
  - Exactly one req: that requester wins.
  - Both req: winner = ~last_winner (round-robin).
  - On a win, register sel = winner, and latch mem_addr/mem_wdata/mem_we from the winner's inputs. Load cnt = MEM_LATENCY-1 and go to ACCESS.
- ACCESS:
  - mem_en = 1; mem_addr/mem_wdata/mem_we hold the latched values (inputs may change freely).
  - gnt of the winner = 1 in the first ACCESS cycle only.
  - cnt decrements each cycle. When cnt == 0, go to DONE and, if the access is a read, capture mem_rdata into rdata at that edge.
  - ACCESS lasts exactly MEM_LATENCY cycles.
- DONE:
  - mem_en = 0; done of the winner = 1 for this single cycle.
  - last_winner = winner; next state is IDLE.
  - Writes leave rdata unchanged.
- Timing, with req seen in IDLE at cycle 0:
  - gnt in cycle 1.
  - done in cycle MEM_LATENCY+1.
  - Next arbitration in cycle MEM_LATENCY+2.
  - Peak throughput: one access per MEM_LATENCY+2 cycles.
- Requester rules:
  - Hold req and operands stable until done is sampled, then deassert req on the following edge.
  - A req dropped mid-access is ignored; the access completes and done still pulses.
  - A req that is still high in IDLE after done is a new request.
- Fairness:
  - With both requests continuously asserted, grants strictly alternate.
  - A lone requester is granted back-to-back with no idle penalty beyond the IDLE cycle.
- sel changes only on the IDLE->ACCESS edge and holds through DONE and IDLE until the next grant.
- gnt0/gnt1 are never both high; done0/done1 are never both high; gnt and done never share a cycle.
- rdata is 32-bit, unmodified from mem_rdata, with no sign or width conversion.

Test Plan:
- MEM_LATENCY=2, reset, then req0=1 with addr0=0x0000_0040, we0=0, and memory returning 0xDEAD_BEEF -> gnt0 pulses in cycle 1, mem_en high in cycles 1-2 with mem_addr=0x40, done0 in cycle 3, rdata=0xDEAD_BEEF, sel=0.
- req0 and req1 asserted together right after reset -> requester 0 granted first, then requester 1. sel goes 0 then 1, and done0 precedes done1 by 4 cycles.
- Both requesters assert req continuously for 6 accesses -> grant order 0,1,0,1,0,1, and every transaction spans exactly 4 cycles.
- req1 write (we1=1, addr1=0x100, wdata1=0x1234_5678) after a read that returned 0xA5A5_A5A5 -> mem_we=1, mem_wdata=0x1234_5678 during ACCESS, done1 pulses, rdata stays 0xA5A5_A5A5.
- reset asserted in the second ACCESS cycle of a req1 read -> next cycle state IDLE with mem_en=0, no done1, rdata=0, sel=0. A following tie is won by requester 0.
- MEM_LATENCY=1, req0 held high with addr0 changing after gnt0 -> mem_addr stays at the latched value, done0 arrives 2 cycles after the request, and a new grant follows in the IDLE cycle after done0.
